uart_rx_shifter: RTL and testbench

UART_RX_SHIFTER -- requirements
Module: uart_rx_shifter

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_shifter_if.sv | 25 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx_shifter.sv | 159 +++++++++++++++
 tb/tb_uart_rx_shifter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// word-length encodings.
package uart_pkg;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_START   = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    typedef enum logic [1:0] {
        WLS_5 = 2'b00,
        WLS_6 = 2'b01,
        WLS_7 = 2'b10,
        WLS_8 = 2'b11
    } wls_e;

    // Index of the final data bit for a given word-length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        case (wls_e'(wls))
            WLS_5:   return 3'd4;
            WLS_6:   return 3'd5;
            WLS_7:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_shifter_if.sv
// Line-control configuration in, received character and status out.
interface uart_rx_shifter_if;

    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] rsr_data;
    logic       receive_done;
    logic       frame_error;
    logic       parity_error;
    logic       uart_break;
    logic       rx_busy;

    modport master (
        output wls, pen, eps, sp,
        input  rsr_data, receive_done, frame_error, parity_error, uart_break, rx_busy
    );

    modport slave (
        input  wls, pen, eps, sp,
        output rsr_data, receive_done, frame_error, parity_error, uart_break, rx_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (RXD, CTS, DSR).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_shifter.sv
// UART receive shift register: 16x oversampled start detection, 5-8 data bits,
// optional parity, first stop bit check and break detection.
module uart_rx_shifter
    import uart_pkg::*;
(
    input  logic              pclk,
    input  logic              preset,
    input  logic              rxd,
    input  logic              baud_tick,
    uart_rx_shifter_if.slave  rx
);

    logic rxd_s;

    sync_2ff #(.RST_VAL(1'b1)) u_rxd_sync (
        .clk (pclk),
        .rst (preset),
        .d_i (rxd),
        .q_o (rxd_s)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] wls_q,   wls_d;
    logic       pen_q,   pen_d;
    logic       eps_q,   eps_d;
    logic       sp_q,    sp_d;
    logic       zero_q,  zero_d;
    logic       perr_q,  perr_d;
    logic [7:0] data_q,  data_d;
    logic       fe_q,    fe_d;
    logic       pe_q,    pe_d;
    logic       brk_q,   brk_d;
    logic       done_q,  done_d;
    logic       exp_par;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wls_d   = wls_q;
        pen_d   = pen_q;
        eps_d   = eps_q;
        sp_d    = sp_q;
        zero_d  = zero_q;
        perr_d  = perr_q;
        data_d  = data_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        brk_d   = brk_q;
        done_d  = 1'b0;
        // Upper shift bits are still zero, so reducing all 8 covers any word length.
        exp_par = sp_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

        if (baud_tick) begin
            cnt_d = cnt_q + 4'd1;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 4'd0;
                    if (!rxd_s) begin
                        state_d = ST_START;
                        bit_d   = 3'd0;
                        shift_d = 8'd0;
                        zero_d  = 1'b1;
                        perr_d  = 1'b0;
                        wls_d   = rx.wls;
                        pen_d   = rx.pen;
                        eps_d   = rx.eps;
                        sp_d    = rx.sp;
                    end
                end
                ST_START: begin
                    if (cnt_q == MID_START) begin
                        cnt_d   = 4'd0;
                        state_d = rxd_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == LAST_SAMPLE) begin
                        shift_d[bit_q] = rxd_s;
                        zero_d         = zero_q & ~rxd_s;
                        bit_d          = bit_q + 3'd1;
                        if (bit_q == last_bit_idx(wls_q))
                            state_d = pen_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == LAST_SAMPLE) begin
                        perr_d  = (rxd_s != exp_par);
                        zero_d  = zero_q & ~rxd_s;
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == LAST_SAMPLE) begin
                        data_d  = shift_q;
                        fe_d    = ~rxd_s;
                        pe_d    = perr_q;
                        brk_d   = zero_q & ~rxd_s;
                        done_d  = 1'b1;
                        state_d = rxd_s ? ST_IDLE : ST_BRK_WAIT;
                    end
                end
                ST_BRK_WAIT: begin
                    cnt_d = 4'd0;
                    if (rxd_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            wls_q   <= 2'b00;
            pen_q   <= 1'b0;
            eps_q   <= 1'b0;
            sp_q    <= 1'b0;
            zero_q  <= 1'b0;
            perr_q  <= 1'b0;
            data_q  <= 8'd0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            brk_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wls_q   <= wls_d;
            pen_q   <= pen_d;
            eps_q   <= eps_d;
            sp_q    <= sp_d;
            zero_q  <= zero_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            brk_q   <= brk_d;
            done_q  <= done_d;
        end
    end

    assign rx.rsr_data     = data_q;
    assign rx.receive_done = done_q;
    assign rx.frame_error  = fe_q;
    assign rx.parity_error = pe_q;
    assign rx.uart_break   = brk_q;
    assign rx.rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_shifter.sv
// Scoreboard bench for uart_rx_shifter: directed frames with hand-computed
// expected characters and status flags.
module tb_uart_rx_shifter;
    import uart_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int BIT_CYC  = OVERSAMPLE * TICK_DIV;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
    } exp_t;

    logic pclk      = 1'b0;
    logic preset    = 1'b1;
    logic rxd       = 1'b1;
    logic baud_tick = 1'b0;

    uart_rx_shifter_if rx ();

    uart_rx_shifter dut (
        .pclk      (pclk),
        .preset    (preset),
        .rxd       (rxd),
        .baud_tick (baud_tick),
        .rx        (rx)
    );

    always #5 pclk = ~pclk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge pclk);
            #1 baud_tick = 1'b1;
            @(posedge pclk);
            #1 baud_tick = 1'b0;
        end
    end

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    int   n_push = 0;
    int   n_before;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe, input logic brk);
        exp_t e;
        e.data = d; e.fe = fe; e.pe = pe; e.brk = brk;
        sb.push_back(e);
        n_push++;
    endtask

    always @(negedge pclk) begin
        if (rx.receive_done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got pulse, expected none");
            end else begin
                mon_e = sb.pop_front();
                chk("rsr_data",     rx.rsr_data,     mon_e.data);
                chk("frame_error",  rx.frame_error,  mon_e.fe);
                chk("parity_error", rx.parity_error, mon_e.pe);
                chk("uart_break",   rx.uart_break,   mon_e.brk);
            end
        end
    end

    task automatic wait_bits(input int n);
        repeat (n * BIT_CYC) @(posedge pclk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
        rx.wls = w; rx.pen = p; rx.eps = e; rx.sp = s;
    endtask

    // Start bit, data LSB first, optional parity, one stop bit; rxd left at stop level.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input logic stop_bit, input logic mess_cfg);
        rxd = 1'b0;
        wait_bits(1);
        if (mess_cfg) set_cfg(~rx.wls, ~rx.pen, ~rx.eps, ~rx.sp);
        for (int i = 0; i < nbits; i++) begin
            rxd = d[i];
            wait_bits(1);
        end
        if (par_en) begin
            rxd = par_bit;
            wait_bits(1);
        end
        rxd = stop_bit;
        wait_bits(1);
        if (mess_cfg) set_cfg(~rx.wls, ~rx.pen, ~rx.eps, ~rx.sp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        chk("rst_rsr_data",     rx.rsr_data,     0);
        chk("rst_frame_error",  rx.frame_error,  0);
        chk("rst_parity_error", rx.parity_error, 0);
        chk("rst_uart_break",   rx.uart_break,   0);
        chk("rst_receive_done", rx.receive_done, 0);
        chk("rst_rx_busy",      rx.rx_busy,      0);
        @(posedge pclk);
        #1 preset = 1'b0;
        wait_bits(2);

        // 8N1 0xA5
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_bits(2);

        // config flipped mid-frame must not matter
        push_exp(8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_bits(2);

        // 5 bits even parity, wrong parity bit
        set_cfg(2'b00, 1'b1, 1'b1, 1'b0);
        push_exp(8'h15, 1'b0, 1'b1, 1'b0);
        send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_bits(2);

        // 7 bits odd parity, correct parity bit
        set_cfg(2'b10, 1'b1, 1'b0, 1'b0);
        push_exp(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_bits(2);

        // stick parity with eps=1 expects a 0 parity bit
        set_cfg(2'b11, 1'b1, 1'b1, 1'b1);
        push_exp(8'h80, 1'b0, 1'b0, 1'b0);
        send_frame(8'h80, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_bits(2);
        push_exp(8'h80, 1'b0, 1'b1, 1'b0);
        send_frame(8'h80, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_bits(2);

        // framing error, line held low afterwards
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_bits(1);
        @(negedge pclk);
        chk("busy_in_brk_wait", rx.rx_busy, 1);
        rxd = 1'b1;
        wait_bits(1);
        @(negedge pclk);
        chk("idle_after_brk_wait", rx.rx_busy, 0);
        wait_bits(1);

        // reset during data bit 3 aborts the frame
        rxd = 1'b0;
        wait_bits(1);
        rxd = 1'b1;
        wait_bits(3);
        repeat (BIT_CYC / 2) @(posedge pclk);
        #1 preset = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        chk("abort_rsr_data",     rx.rsr_data,     0);
        chk("abort_frame_error",  rx.frame_error,  0);
        chk("abort_receive_done", rx.receive_done, 0);
        chk("abort_rx_busy",      rx.rx_busy,      0);
        @(posedge pclk);
        #1 preset = 1'b0;
        wait_bits(1);
        push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_bits(2);

        // break: line low for two frame times
        push_exp(8'h00, 1'b1, 1'b0, 1'b1);
        rxd = 1'b0;
        wait_bits(20);
        @(negedge pclk);
        chk("busy_during_break", rx.rx_busy, 1);
        rxd = 1'b1;
        wait_bits(2);
        @(negedge pclk);
        chk("idle_after_break", rx.rx_busy, 0);
        chk("break_done_count", n_done, n_push);

        // 4-tick glitch is a false start
        n_before = n_done;
        rxd = 1'b0;
        repeat (4 * TICK_DIV) @(posedge pclk);
        #1 rxd = 1'b1;
        wait_bits(2);
        @(negedge pclk);
        chk("false_start_busy", rx.rx_busy, 0);
        chk("false_start_done", n_done, n_before);

        wait_bits(1);
        chk("queue_empty", sb.size(), 0);
        chk("done_count", n_done, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
